round_sequencer: RTL
====================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 5, rounds per game (1..15).
REQ-002 Parameter SHOW_SECS, default 3, seconds symbols are shown per round (1..15).
REQ-003 Parameter TIMEOUT_SECS, default 8, seconds allowed for postSig before a round is forfeited (1..15).
REQ-004 Clk100M  in  1  sole clock; all logic is clocked on its rising edge.
REQ-005 Rst_n  in  1  asynchronous, active-low reset.
REQ-006 Clk1Hz  in  1  slow clock, sampled as data through a 2-flop synchroniser; each synchronised rising edge is one tick.
REQ-007 startBtn  in  1  debounced level; a rising edge starts the game.
REQ-008 postSig  in  1  one-cycle pulse from the answer-period block meaning the answer window has closed.
REQ-009 userCount  in  8  player's count, valid when postSig is high.
REQ-010 targetCount  in  8  symbol-generator count, sampled on entry to SHOW.
REQ-011 answerSig  out  1  one-cycle pulse that opens the answer window.
REQ-012 showEn  out  1  high throughout SHOW; enables symbol generation.
REQ-013 roundNum  out  4  current round, 0 when idle.
REQ-014 score  out  4  correct answers this game.
REQ-015 gameOver  out  1  high in DONE.
REQ-016 roundSeg, scoreSeg  out  8 each  seven-segment patterns for roundNum and score: bit0=a ... bit6=g, bit7=dp, 1=lit; hex digits 0-F.

Function
REQ-017 The FSM SHALL have the states IDLE, SHOW, ASK, WAIT_POST, SCORE and DONE.
REQ-018 IDLE/DONE: a startBtn rising edge SHALL clear score, set roundNum=1, clear secCnt, latch targetCount and go to SHOW on the next cycle.
REQ-019 SHOW: showEn=1; secCnt increments per tick; the tick taken with secCnt==SHOW_SECS-1 SHALL clear secCnt and move to ASK.
REQ-020 ASK SHALL last exactly one cycle with answerSig=1, then go to WAIT_POST; answerSig SHALL be 0 in every other state.
REQ-021 WAIT_POST: postSig=1 SHALL latch userCount and go to SCORE; postSig SHALL be ignored in all other states.
REQ-022 SCORE SHALL last one cycle: if latched userCount==latched targetCount, score increments and saturates at 15.
REQ-023 From SCORE: if roundNum==NUM_ROUNDS, go to DONE; otherwise increment roundNum, latch targetCount and go to SHOW.
REQ-024 DONE: gameOver=1; roundNum and score hold their values.
REQ-025 startBtn edges SHALL be ignored outside IDLE/DONE; holding startBtn high SHALL produce a single start only.
REQ-026 A tick and a state change in the same cycle: the tick SHALL apply to the state being left, never the new one.
REQ-027 Seg outputs SHALL be registered, one cycle after roundNum and score.

Reset
REQ-028 Rst_n low SHALL force IDLE, secCnt=0, answerSig=0, showEn=0, roundNum=0, score=0, gameOver=0, latches=0, roundSeg=scoreSeg=8'h3F, and clear the synchroniser and edge-detect flops, asynchronously and at any point mid-game.

Configuration
REQ-029 With ROUND_TIMEOUT_EN defined, WAIT_POST SHALL count ticks; if TIMEOUT_SECS ticks pass without postSig it goes to SCORE with no point awarded; postSig arriving in the same cycle as the timeout takes priority.
REQ-030 Without ROUND_TIMEOUT_EN, WAIT_POST SHALL wait indefinitely and no timeout logic is built.

Structure
REQ-031 The package round_seq_pkg SHALL hold the state enum, the seven-segment lookup constant and the width constants.
REQ-032 The sub-module tick_edge_det SHALL implement the Clk1Hz synchroniser and the rising-edge pulse.

Verification
REQ-033 Reset, then a startBtn edge with targetCount=7 -> showEn high for 3 ticks, then one answerSig pulse, roundNum=1.
REQ-034 postSig with userCount=7 -> score=1 and scoreSeg=8'h06 one cycle after score.
REQ-035 Five rounds with alternating correct/wrong answers -> gameOver=1, score=3, roundNum=5; a further startBtn edge restarts at roundNum=1, score=0.
REQ-036 postSig pulses during SHOW plus startBtn held high -> no state effect and no second start.
REQ-037 ROUND_TIMEOUT_EN with no postSig -> SCORE after 8 ticks, no point awarded; postSig coincident with the 8th tick -> answer is scored.
REQ-038 Rst_n asserted during WAIT_POST -> all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/round_seq_pkg.sv
// rtl/round_seq_pkg.sv - shared types and constants for the round sequencer
//
// Holds the FSM state enum, datapath width constants and the seven-segment
// lookup (bit0=a ... bit6=g, bit7=dp, 1=lit) for hex digits 0-F.
package round_seq_pkg;

  localparam int ROUND_W = 4;
  localparam int SCORE_W = 4;
  localparam int SEC_W   = 4;
  localparam int COUNT_W = 8;
  localparam int SEG_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_ASK,
    ST_WAIT_POST,
    ST_SCORE,
    ST_DONE
  } state_e;

  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [SEG_W-1:0] seg7(input logic [3:0] digit);
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/tick_edge_det.sv
// rtl/tick_edge_det.sv - slow-clock synchroniser and rising-edge tick pulse
//
// Ports:
//   clk_i    fast system clock
//   rst_n_i  asynchronous active-low reset
//   slow_i   slow clock, treated as asynchronous data
//   tick_o   one-cycle pulse per synchronised rising edge of slow_i
module tick_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic slow_i,
  output logic tick_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= slow_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game round FSM: show, ask, collect answer, score
//
// Optional feature macro: ROUND_TIMEOUT_EN (forfeit a round after
// TIMEOUT_SECS ticks in WAIT_POST without postSig).
//
// Ports:
//   Clk100M      sole clock, rising edge
//   Rst_n        asynchronous active-low reset
//   Clk1Hz       slow clock, synchronised; each rising edge is one tick
//   startBtn     debounced level, rising edge starts a game in IDLE/DONE
//   postSig      one-cycle pulse, answer window closed
//   userCount    player's count, valid with postSig
//   targetCount  symbol-generator count, latched on entry to SHOW
//   answerSig    one-cycle pulse opening the answer window (ASK)
//   showEn       high throughout SHOW
//   roundNum     current round, 0 when idle
//   score        correct answers this game, saturating at 15
//   gameOver     high in DONE
//   roundSeg     registered seven-segment pattern of roundNum
//   scoreSeg     registered seven-segment pattern of score
module round_sequencer
  import round_seq_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS   = 5,
  parameter int unsigned SHOW_SECS    = 3,
  parameter int unsigned TIMEOUT_SECS = 8
) (
  input  logic               Clk100M,
  input  logic               Rst_n,
  input  logic               Clk1Hz,
  input  logic               startBtn,
  input  logic               postSig,
  input  logic [COUNT_W-1:0] userCount,
  input  logic [COUNT_W-1:0] targetCount,
  output logic               answerSig,
  output logic               showEn,
  output logic [ROUND_W-1:0] roundNum,
  output logic [SCORE_W-1:0] score,
  output logic               gameOver,
  output logic [SEG_W-1:0]   roundSeg,
  output logic [SEG_W-1:0]   scoreSeg
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $error("NUM_ROUNDS must be 1..15");
  end
  if (SHOW_SECS < 1 || SHOW_SECS > 15) begin : g_bad_show
    $error("SHOW_SECS must be 1..15");
  end
  if (TIMEOUT_SECS < 1 || TIMEOUT_SECS > 15) begin : g_bad_timeout
    $error("TIMEOUT_SECS must be 1..15");
  end

  state_e               state_q, state_d;
  logic [SEC_W-1:0]     sec_q, sec_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COUNT_W-1:0]   target_q, target_d;
  logic [COUNT_W-1:0]   user_q, user_d;
  logic                 start_q;
  logic [SEG_W-1:0]     round_seg_q, score_seg_q;
  logic                 tick;
  logic                 start_edge;
  logic                 point_ok;
`ifdef ROUND_TIMEOUT_EN
  logic                 timeout_q, timeout_d;
`endif

  tick_edge_det u_tick (
    .clk_i   (Clk100M),
    .rst_n_i (Rst_n),
    .slow_i  (Clk1Hz),
    .tick_o  (tick)
  );

  // startBtn is already debounced, so one flop is enough to find its edge;
  // a held button never re-triggers because start_q stays high.
  assign start_edge = startBtn & ~start_q;

`ifdef ROUND_TIMEOUT_EN
  assign point_ok = (user_q == target_q) && !timeout_q;
`else
  assign point_ok = (user_q == target_q);
`endif

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    round_d  = round_q;
    score_d  = score_q;
    target_d = target_q;
    user_d   = user_q;
`ifdef ROUND_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    // A tick is only acted on by the state that is current when it arrives,
    // so a tick coinciding with a transition never leaks into the new state.
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          score_d  = '0;
          round_d  = ROUND_W'(1);
          sec_d    = '0;
          target_d = targetCount;
`ifdef ROUND_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          if (sec_q == SEC_W'(SHOW_SECS - 1)) begin
            sec_d   = '0;
            state_d = ST_ASK;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end
      ST_ASK: begin
        sec_d   = '0;
        state_d = ST_WAIT_POST;
      end
      ST_WAIT_POST: begin
        // postSig is tested first so an answer coinciding with the timeout
        // tick is still scored.
        if (postSig) begin
          user_d  = userCount;
          sec_d   = '0;
          state_d = ST_SCORE;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tick) begin
          if (sec_q == SEC_W'(TIMEOUT_SECS - 1)) begin
            sec_d     = '0;
            timeout_d = 1'b1;
            state_d   = ST_SCORE;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end
`endif
      end
      ST_SCORE: begin
        if (point_ok && (score_q != {SCORE_W{1'b1}})) begin
          score_d = score_q + SCORE_W'(1);
        end
`ifdef ROUND_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        if (round_q == ROUND_W'(NUM_ROUNDS)) begin
          state_d = ST_DONE;
        end else begin
          round_d  = round_q + ROUND_W'(1);
          target_d = targetCount;
          sec_d    = '0;
          state_d  = ST_SHOW;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      round_q     <= '0;
      score_q     <= '0;
      target_q    <= '0;
      user_q      <= '0;
      start_q     <= 1'b0;
      round_seg_q <= seg7(4'h0);
      score_seg_q <= seg7(4'h0);
`ifdef ROUND_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      round_q     <= round_d;
      score_q     <= score_d;
      target_q    <= target_d;
      user_q      <= user_d;
      start_q     <= startBtn;
      // Driven from the registered values, hence one cycle behind them.
      round_seg_q <= seg7(round_q);
      score_seg_q <= seg7(score_q);
`ifdef ROUND_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign answerSig = (state_q == ST_ASK);
  assign showEn    = (state_q == ST_SHOW);
  assign gameOver  = (state_q == ST_DONE);
  assign roundNum  = round_q;
  assign score     = score_q;
  assign roundSeg  = round_seg_q;
  assign scoreSeg  = score_seg_q;

endmodule
